alu_exec_unit: RTL and testbench

Parametrised execute unit for the RISC-V core. It decodes ALUOP/funct3/funct7 into a full RV32I ALU operation set plus an iterative unsigned multiplier (MUL, MULHU), computes the result, and delivers it through a one-entry valid/ready output buffer. It sits between decode and writeback/memory-controller address generation. It makes a stall-capable multi-cycle execute stage possible without changing the decoder interface.

---
 rtl/alu_exec_unit.sv | 182 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I-style execute stage with an iterative unsigned
// multiplier (MUL, MULHU) and a one-entry valid/ready result buffer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; single-cycle ops complete on accept
// MUL   | shift-add multiply in progress, one partial product per cycle
module alu_exec_unit #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOP,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            op_5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic [SHW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic                mul_hi_q, mul_hi_d;

    logic                accept;
    logic                pop;
    logic [SHW-1:0]      shamt;
    logic                is_mul;
    logic                mul_ok;
    logic [XLEN-1:0]     alu_res;
    logic                alu_ill;
    logic [XLEN:0]       acc_sum;
    logic [2*XLEN-1:0]   acc_step;
    logic [XLEN-1:0]     mul_res;

    // in_ready only looks at state and out_ready, never at in_valid
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    // Operation decode and single-cycle ALU result
    always_comb begin
        shamt   = src_b[SHW-1:0];
        is_mul  = (ALUOP == 2'b10) && op_5 && funct7_0;
        mul_ok  = is_mul && MUL_EN && ((funct3 == 3'b000) || (funct3 == 3'b011));
        alu_res = '0;
        alu_ill = 1'b0;
        case (ALUOP)
            2'b00: alu_res = src_a + src_b;
            2'b01: alu_res = src_a - src_b;
            2'b11: alu_res = src_b;
            default: begin
                if (is_mul) begin
                    // legal multiplies leave through the MUL state instead
                    alu_ill = !mul_ok;
                    alu_res = '0;
                end else begin
                    case (funct3)
                        3'b000:  alu_res = (op_5 && funct7_5) ? (src_a - src_b) : (src_a + src_b);
                        3'b001:  alu_res = src_a << shamt;
                        3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
                        3'b011:  alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
                        3'b100:  alu_res = src_a ^ src_b;
                        3'b101:  alu_res = funct7_5 ? $unsigned($signed(src_a) >>> shamt)
                                                    : (src_a >> shamt);
                        3'b110:  alu_res = src_a | src_b;
                        default: alu_res = src_a & src_b;
                    endcase
                end
            end
        endcase
    end

    // One shift-add step: conditional add into the upper half, then shift right
    always_comb begin
        acc_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
        acc_step = acc_q[0] ? {acc_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        mul_res  = mul_hi_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    end

    // Next-state, multiplier datapath and output buffer update
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mul_hi_d    = mul_hi_q;

        if (pop) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mul_ok) begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        acc_d    = {{XLEN{1'b0}}, src_b};
                        mcand_d  = src_a;
                        mul_hi_d = (funct3 == 3'b011);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        illegal_d   = alu_ill;
                    end
                end
            end
            default: begin
                acc_d = acc_step;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(XLEN-1)) begin
                    // buffer is known empty here: accept required it to drain
                    state_d     = IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    result_d    = mul_res;
                    zero_d      = (mul_res == '0);
                    illegal_d   = 1'b0;
                end
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mul_hi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mul_hi_q    <= mul_hi_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: decode, multiply latency, backpressure,
// mid-multiply reset. A second instance built without multiply support
// shares the inputs so the illegal-multiply path can be observed.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready1;
    logic [1:0]  ALUOP;
    logic [2:0]  funct3;
    logic        funct7_5, funct7_0, op_5;
    logic [31:0] src_a, src_b;
    logic        out_valid, out_valid1;
    logic        out_ready;
    logic [31:0] result, result1;
    logic        zero, zero1;
    logic        illegal_op, illegal_op1;

    int checks = 0;
    int errors = 0;
    int lat;
    bit seen;

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOP(ALUOP), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .op_5(op_5), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal_op(illegal_op)
    );

    alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .ALUOP(ALUOP), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
        .op_5(op_5), .src_a(src_a), .src_b(src_b), .out_valid(out_valid1),
        .out_ready(out_ready), .result(result1), .zero(zero1), .illegal_op(illegal_op1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                          input logic f70, input logic o5, input logic [31:0] a,
                          input logic [31:0] b);
        ALUOP = aop; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op_5 = o5;
        src_a = a; src_b = b;
    endtask

    // Present one request for one edge; returns #1 after that edge
    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                         input logic f70, input logic o5, input logic [31:0] a,
                         input logic [31:0] b);
        set_op(aop, f3, f75, f70, o5, a, b);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    endtask

    // Count edges until out_valid, checking in_ready stays low meanwhile
    task automatic wait_result(input string tag, input int exp_lat);
        lat = 0;
        seen = 1'b0;
        chk({tag, "_ready_after_accept"}, in_ready, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) seen = 1'b1;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_ready_low"}, seen, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", zero, 1'b0);
        chk("rst_illegal", illegal_op, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", in_ready, 1'b1);

        // funct-decoded sub (R-type, funct7_5=1)
        issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_result", result, 32'hFFFF_FFFE);
        chk("sub_zero", zero, 1'b0);
        chk("sub_illegal", illegal_op, 1'b0);

        // back-to-back single-cycle ops, one result per cycle
        issue(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4);
        chk("sra", result, 32'hF800_0000);
        issue(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4);
        chk("srl", result, 32'h0800_0000);
        issue(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
        chk("slt", result, 32'd1);
        issue(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1);
        chk("sltu", result, 32'd0);
        chk("sltu_zero", zero, 1'b1);
        chk("sltu_valid", out_valid, 1'b1);
        issue(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0000_0024);
        chk("sll_shamt_mask", result, 32'h0000_0030);
        issue(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0_1234, 32'h0FF0_1234);
        chk("xor", result, 32'hFF00_0000);
        issue(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF000_000F, 32'h0F00_00F0);
        chk("or", result, 32'hFF00_00FF);
        issue(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'h3C3C_3C3C);
        chk("and", result, 32'h3030_3030);
        issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7);
        chk("itype_add", result, 32'd12);
        issue(2'b00, 3'b111, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1);
        chk("aluop_add_wrap", result, 32'h0);
        chk("aluop_add_zero", zero, 1'b1);
        issue(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd3);
        chk("aluop_sub", result, 32'd7);
        issue(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'hCAFE_F00D);
        chk("pass_b", result, 32'hCAFE_F00D);

        // unsupported multiply encoding
        issue(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd9, 32'd9);
        chk("ill_valid", out_valid, 1'b1);
        chk("ill_flag", illegal_op, 1'b1);
        chk("ill_result", result, 32'h0);
        chk("ill_zero", zero, 1'b1);

        // MUL; the MUL_EN=0 instance flags the same encoding illegal in one cycle
        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2);
        chk("nomul_valid", out_valid1, 1'b1);
        chk("nomul_illegal", illegal_op1, 1'b1);
        chk("nomul_result", result1, 32'h0);
        chk("nomul_zero", zero1, 1'b1);
        chk("mul_not_early", out_valid, 1'b0);
        wait_result("mul", 32);
        chk("mul_result", result, 32'hFFFF_FFFE);
        chk("mul_illegal", illegal_op, 1'b0);

        issue(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2);
        wait_result("mulhu", 32);
        chk("mulhu_result", result, 32'h0000_0001);

        issue(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("mulhu_max", 32);
        chk("mulhu_max_result", result, 32'hFFFF_FFFE);

        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'd9);
        wait_result("mul2", 32);
        chk("mul2_result", result, 32'hA3D7_0A38);

        // backpressure: fill buffer, then hold a request while out_ready=0
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
        chk("bp_first", result, 32'd2);
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd10);
        in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (in_ready || result !== 32'd2 || !out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("bp_hold", seen, 1'b0);
        chk("bp_result_stable", result, 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", in_ready, 1'b1);
        @(posedge clk); #1;
        chk("bp_pop2", result, 32'd20);
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd100, 32'd200);
        @(posedge clk); #1;
        chk("bp_pop3", result, 32'd300);
        set_op(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd50, 32'd8);
        @(posedge clk); #1;
        chk("bp_pop4", result, 32'd42);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 1'b0);

        // reset in the middle of a multiply
        issue(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd7, 32'd6);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 1'b0);
        chk("abort_result", result, 32'h0);
        chk("abort_zero", zero, 1'b0);
        chk("abort_illegal", illegal_op, 1'b0);
        chk("abort_ready", in_ready, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_spurious", seen, 1'b0);
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);
        chk("post_reset_valid", out_valid, 1'b1);
        chk("post_reset_add", result, 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
